// File: rtl/exc_pipe_ctrl.sv
// Exception/interrupt tracking for the five-stage pipeline: carries fault codes
// D->E->M (oldest fault wins), checks M-stage addresses, and raises the request to CP0.
module exc_pipe_ctrl #(
    parameter int unsigned NUM_HWINT  = 6,
    parameter logic [31:0] DM_TOP     = 32'h0000_2fff,
    parameter int unsigned NUM_TIMERS = 2,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7f00,
    parameter logic [31:0] IG_BASE    = 32'h0000_7f20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           F_code,
    input  logic                 D_syscall,
    input  logic                 D_ri,
    input  logic                 E_ov_en,
    input  logic                 E_overflow,
    input  logic [31:0]          M_instr,
    input  logic [31:0]          M_addr,
    input  logic                 M_ov,
    input  logic                 D_en,
    input  logic                 E_clr,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic [NUM_HWINT-1:0] im,
    input  logic                 ie,
    input  logic                 eret_M,
    output logic [4:0]           D_code,
    output logic [4:0]           E_code,
    output logic [4:0]           M_code,
    output logic                 exc_req,
    output logic                 exc_is_int,
    output logic [NUM_HWINT-1:0] ip,
    output logic                 exl
);

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    logic [4:0]           r_d_code;
    logic [4:0]           r_e_code;
    logic [4:0]           r_m_code;
    logic [NUM_HWINT-1:0] r_sync;
    logic [NUM_HWINT-1:0] r_ip;
    logic                 r_exl;

    logic       w_lw, w_lh, w_lb, w_sw, w_sh, w_sb;
    logic       w_in_dm, w_in_tmr, w_tmr_cnt, w_in_ig, w_legal;
    logic       w_adel, w_ades;
    logic       w_int_pend;
    logic [4:0] w_d_local, w_e_local, w_m_local;

    assign w_lw = (M_instr[31:26] == OP_LW);
    assign w_lh = (M_instr[31:26] == OP_LH);
    assign w_lb = (M_instr[31:26] == OP_LB);
    assign w_sw = (M_instr[31:26] == OP_SW);
    assign w_sh = (M_instr[31:26] == OP_SH);
    assign w_sb = (M_instr[31:26] == OP_SB);

    // MMIO map lookup: timer windows are 12 bytes on a 16-byte stride
    always_comb begin
        w_in_tmr  = 1'b0;
        w_tmr_cnt = 1'b0;
        for (int k = 0; k < int'(NUM_TIMERS); k++) begin
            if ((M_addr >= TIMER_BASE + 32'(16 * k)) &&
                (M_addr <= TIMER_BASE + 32'(16 * k) + 32'd11)) begin
                w_in_tmr = 1'b1;
            end else begin
                w_in_tmr = w_in_tmr;
            end
            if (M_addr == TIMER_BASE + 32'(16 * k) + 32'd8) begin
                w_tmr_cnt = 1'b1;
            end else begin
                w_tmr_cnt = w_tmr_cnt;
            end
        end
    end

    assign w_in_dm = (M_addr <= DM_TOP);
    assign w_in_ig = (M_addr >= IG_BASE) && (M_addr <= IG_BASE + 32'd3);
    assign w_legal = w_in_dm | w_in_tmr | w_in_ig;

    assign w_adel = (w_lw | w_lh | w_lb) &
                    ((w_lw & (M_addr[1:0] != 2'b00)) | (w_lh & M_addr[0]) |
                     ((w_lh | w_lb) & w_in_tmr) | M_ov | !w_legal);

    assign w_ades = (w_sw | w_sh | w_sb) &
                    ((w_sw & (M_addr[1:0] != 2'b00)) | (w_sh & M_addr[0]) |
                     ((w_sh | w_sb) & w_in_tmr) | M_ov | !w_legal |
                     w_tmr_cnt | ((w_sh | w_sb) & w_in_ig));

    // Local faults are suppressed while reset is held so every output reads zero
    assign w_d_local = !reset ? 5'd0 : D_syscall ? 5'd8 : D_ri ? 5'd10 : 5'd0;
    assign w_e_local = (reset & E_ov_en & E_overflow) ? 5'd12 : 5'd0;
    assign w_m_local = !reset ? 5'd0 : w_adel ? 5'd4 : w_ades ? 5'd5 : 5'd0;

    assign D_code = (r_d_code != 5'd0) ? r_d_code : w_d_local;
    assign E_code = (r_e_code != 5'd0) ? r_e_code : w_e_local;
    assign M_code = (r_m_code != 5'd0) ? r_m_code : w_m_local;

    assign w_int_pend = (|(r_ip & im)) & ie & !r_exl;
    assign exc_req    = w_int_pend | ((M_code != 5'd0) & !r_exl);
    assign exc_is_int = w_int_pend;
    assign ip         = r_ip;
    assign exl        = r_exl;

    // Stage code registers; a taken request flushes all three
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_code <= 5'd0;
            r_e_code <= 5'd0;
            r_m_code <= 5'd0;
        end else if (exc_req) begin
            r_d_code <= 5'd0;
            r_e_code <= 5'd0;
            r_m_code <= 5'd0;
        end else begin
            if (D_en) begin
                r_d_code <= F_code;
            end
            if (E_clr) begin
                r_e_code <= 5'd0;
            end else if (D_en) begin
                r_e_code <= D_code;
            end
            r_m_code <= E_code;
        end
    end

    // Two-flop synchroniser for the raw interrupt lines
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_ip   <= '0;
        end else begin
            r_sync <= hw_int;
            r_ip   <= r_sync;
        end
    end

    // Exception level: entering an exception outranks a simultaneous eret
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exl <= 1'b0;
        end else if (exc_req) begin
            r_exl <= 1'b1;
        end else if (eret_M) begin
            r_exl <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exc_pipe_ctrl.sv
// Directed bench for exc_pipe_ctrl: pipeline merge, address map, stall/flush,
// interrupts and EXL handling, each against hand-computed values.
module tb_exc_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  F_code;
    logic        D_syscall, D_ri, E_ov_en, E_overflow;
    logic [31:0] M_instr, M_addr;
    logic        M_ov, D_en, E_clr;
    logic [5:0]  hw_int, im;
    logic        ie, eret_M;
    logic [4:0]  D_code, E_code, M_code;
    logic        exc_req, exc_is_int;
    logic [5:0]  ip;
    logic        exl;

    int n_total = 0;
    int n_bad   = 0;

    exc_pipe_ctrl dut (
        .clk(clk), .reset(reset), .F_code(F_code), .D_syscall(D_syscall), .D_ri(D_ri),
        .E_ov_en(E_ov_en), .E_overflow(E_overflow), .M_instr(M_instr), .M_addr(M_addr),
        .M_ov(M_ov), .D_en(D_en), .E_clr(E_clr), .hw_int(hw_int), .im(im), .ie(ie),
        .eret_M(eret_M), .D_code(D_code), .E_code(E_code), .M_code(M_code),
        .exc_req(exc_req), .exc_is_int(exc_is_int), .ip(ip), .exl(exl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mem_case(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic ov, input logic [4:0] exp);
        step();
        M_instr = {op, 26'd0};
        M_addr  = addr;
        M_ov    = ov;
        #1;
        check_eq(tag, 32'(M_code), 32'(exp));
    endtask

    initial begin
        reset = 1'b0; F_code = 5'd0; D_syscall = 1'b0; D_ri = 1'b0;
        E_ov_en = 1'b0; E_overflow = 1'b0; M_instr = 32'd0; M_addr = 32'd0;
        M_ov = 1'b0; D_en = 1'b0; E_clr = 1'b0; hw_int = 6'd0; im = 6'd0;
        ie = 1'b0; eret_M = 1'b0;
        #3;
        check_eq("rst_dcode", 32'(D_code), 32'd0);
        check_eq("rst_ecode", 32'(E_code), 32'd0);
        check_eq("rst_mcode", 32'(M_code), 32'd0);
        check_eq("rst_req", 32'(exc_req), 32'd0);
        check_eq("rst_exl", 32'(exl), 32'd0);
        #4 reset = 1'b1;

        // oldest fault wins down the pipe
        step();
        F_code = 5'd4; D_en = 1'b1;
        step();
        D_syscall = 1'b1; #1;
        check_eq("old_d", 32'(D_code), 32'd4);
        F_code = 5'd0;
        step();
        D_syscall = 1'b0; E_ov_en = 1'b1; E_overflow = 1'b1; #1;
        check_eq("old_e", 32'(E_code), 32'd4);
        step();
        E_ov_en = 1'b0; E_overflow = 1'b0; #1;
        check_eq("old_m", 32'(M_code), 32'd4);
        check_eq("old_req", 32'(exc_req), 32'd1);
        check_eq("old_isint", 32'(exc_is_int), 32'd0);
        step(); #1;
        check_eq("flush_d", 32'(D_code), 32'd0);
        check_eq("flush_e", 32'(E_code), 32'd0);
        check_eq("flush_m", 32'(M_code), 32'd0);
        check_eq("flush_exl", 32'(exl), 32'd1);
        check_eq("flush_req", 32'(exc_req), 32'd0);

        // M-stage address map (exl=1 keeps requests quiet)
        D_en = 1'b0;
        mem_case("lw_dm_top", 6'b100011, 32'h0000_2ffc, 1'b0, 5'd0);
        mem_case("lw_past_dm", 6'b100011, 32'h0000_3000, 1'b0, 5'd4);
        mem_case("lh_timer", 6'b100001, 32'h0000_7f04, 1'b0, 5'd4);
        mem_case("sw_count", 6'b101011, 32'h0000_7f08, 1'b0, 5'd5);
        mem_case("sw_ig", 6'b101011, 32'h0000_7f20, 1'b0, 5'd0);
        mem_case("sb_ig", 6'b101000, 32'h0000_7f20, 1'b0, 5'd5);
        mem_case("add_nomem", 6'b000000, 32'h0000_3000, 1'b0, 5'd0);
        mem_case("sw_timer1", 6'b101011, 32'h0000_7f10, 1'b0, 5'd0);
        mem_case("lw_tmr_gap", 6'b100011, 32'h0000_7f0c, 1'b0, 5'd4);
        mem_case("lw_misalign", 6'b100011, 32'h0000_2ffe, 1'b0, 5'd4);
        mem_case("sh_odd", 6'b101001, 32'h0000_0101, 1'b0, 5'd5);
        mem_case("lw_mov", 6'b100011, 32'h0000_0000, 1'b1, 5'd4);
        mem_case("sw_count1", 6'b101011, 32'h0000_7f18, 1'b0, 5'd5);
        mem_case("lb_dm", 6'b100000, 32'h0000_0003, 1'b0, 5'd0);
        M_instr = 32'd0; M_addr = 32'd0; M_ov = 1'b0;

        // stall and bubble
        step();
        D_en = 1'b1; D_syscall = 1'b1;
        step(); #1;
        check_eq("e_load", 32'(E_code), 32'd8);
        D_en = 1'b0; D_syscall = 1'b0; D_ri = 1'b1;
        step(); #1;
        check_eq("e_stall", 32'(E_code), 32'd8);
        E_clr = 1'b1; D_en = 1'b1;
        step(); #1;
        check_eq("e_bubble", 32'(E_code), 32'd0);
        check_eq("exl_m8", 32'(M_code), 32'd8);
        check_eq("exl_noreq8", 32'(exc_req), 32'd0);
        E_clr = 1'b0; D_en = 1'b0; D_ri = 1'b0;

        // EXL blocks requests until eret
        E_ov_en = 1'b1; E_overflow = 1'b1;
        step();
        E_ov_en = 1'b0; E_overflow = 1'b0; #1;
        check_eq("exl_m12", 32'(M_code), 32'd12);
        check_eq("exl_noreq12", 32'(exc_req), 32'd0);
        im = 6'b000100; ie = 1'b1; hw_int = 6'b000100;
        step(); step(); #1;
        check_eq("exl_ip", 32'(ip), 32'h4);
        check_eq("exl_int_blk", 32'(exc_req), 32'd0);
        eret_M = 1'b1;
        step();
        eret_M = 1'b0; #1;
        check_eq("eret_exl", 32'(exl), 32'd0);
        check_eq("eret_req", 32'(exc_req), 32'd1);
        check_eq("eret_isint", 32'(exc_is_int), 32'd1);
        hw_int = 6'd0; eret_M = 1'b1;
        step();
        eret_M = 1'b0; #1;
        check_eq("req_eret_exl", 32'(exl), 32'd1);
        step(); #1;
        check_eq("ip_clear", 32'(ip), 32'd0);
        eret_M = 1'b1;
        step();
        eret_M = 1'b0; #1;
        check_eq("idle_exl", 32'(exl), 32'd0);
        check_eq("idle_req", 32'(exc_req), 32'd0);

        // interrupt latency and priority over an M fault
        hw_int = 6'b000100;
        step(); #1;
        check_eq("int_1clk", 32'(exc_req), 32'd0);
        step();
        M_instr = {6'b101000, 26'd0}; M_addr = 32'h0000_7f20; #1;
        check_eq("int_ip", 32'(ip), 32'h4);
        check_eq("int_mcode", 32'(M_code), 32'd5);
        check_eq("int_req", 32'(exc_req), 32'd1);
        check_eq("int_isint", 32'(exc_is_int), 32'd1);

        // reset mid-run with faults held
        F_code = 5'd4; D_en = 1'b1; D_syscall = 1'b1; E_ov_en = 1'b1; E_overflow = 1'b1;
        hw_int = 6'h3f; im = 6'h3f;
        step(); step(); step();
        #1 reset = 1'b0;
        #1;
        check_eq("mrst_dcode", 32'(D_code), 32'd0);
        check_eq("mrst_ecode", 32'(E_code), 32'd0);
        check_eq("mrst_mcode", 32'(M_code), 32'd0);
        check_eq("mrst_req", 32'(exc_req), 32'd0);
        check_eq("mrst_ip", 32'(ip), 32'd0);
        check_eq("mrst_exl", 32'(exl), 32'd0);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/exc_pipe_ctrl.md
Name: exc_pipe_ctrl

Overview:
- Parametrised exception/interrupt tracking unit for the five-stage MIPS pipeline.
- Registers exception codes stage to stage (D→E→M), merging each stage's locally detected faults with an "oldest fault wins" rule.
- Performs M-stage load/store address checks against a configurable MMIO map.
- Synchronises and masks hardware interrupts, and raises a single registered-state exception request with EXL tracking for the CP0/flush logic.

Parameters:
- NUM_HWINT, 6, number of hardware interrupt lines.
- DM_TOP, 32'h2fff, highest legal DM byte address (DM spans 0..DM_TOP).
- NUM_TIMERS, 2, timer instances; timer k occupies TIMER_BASE+16k .. TIMER_BASE+16k+11.
- TIMER_BASE, 32'h7f00, base of timer 0.
- IG_BASE, 32'h7f20, interrupt generator base (4 bytes, word access only).

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-low reset.
- F_code, in, 5, code produced in F (4 = fetch AdEL, 0 = none).
- D_syscall, in, 1, D instruction is syscall.
- D_ri, in, 1, D instruction is reserved.
- E_ov_en, in, 1, E instruction traps on overflow (add/sub/addi).
- E_overflow, in, 1, E ALU signed overflow.
- M_instr, in, 32, M-stage instruction.
- M_addr, in, 32, M-stage effective address.
- M_ov, in, 1, address-calculation overflow carried from E.
- D_en, in, 1, D/E pipeline register advance enable (0 = stall).
- E_clr, in, 1, insert bubble into E.
- hw_int, in, NUM_HWINT, raw interrupt lines.
- im, in, NUM_HWINT, interrupt mask from SR.
- ie, in, 1, global interrupt enable.
- eret_M, in, 1, eret in M.
- D_code, out, 5, merged D code.
- E_code, out, 5, merged E code.
- M_code, out, 5, merged M code.
- exc_req, out, 1, take exception/interrupt this cycle.
- exc_is_int, out, 1, request is interrupt (cause 0).
- ip, out, NUM_HWINT, synchronised pending lines.
- exl, out, 1, exception level.

Behaviour:
- Reset (reset=0, async): all stage code registers=0, sync flops=0, exl=0. Outputs then: D_code=E_code=M_code=0, exc_req=0, ip=0.
- Merge rule (combinational, all stages): an inherited nonzero code is kept; otherwise the local code applies; otherwise 0.
  - D local: syscall→8, else ri→10.
  - E local: E_ov_en & E_overflow→12.
  - M local: AdEL→4, else AdES→5.
- Stage registers:
  - D_reg←F_code when D_en.
  - E_reg←0 when E_clr, else D_code when D_en. E_clr overrides D_en.
  - M_reg←E_code every cycle.
  - exc_req=1 clears all three registers at the next edge (flush); this has priority over D_en/E_clr.
- M decode: lw/lh/lb/sw/sh/sb from opcode (100011, 100001, 100000, 101011, 101001, 101000).
- legal(addr) = within DM, any timer window, or IG window.
- AdEL (load) if any of:
  - lw misaligned (addr[1:0]≠0);
  - lh odd;
  - lh/lb into any timer window;
  - M_ov;
  - !legal.
- AdES (store) if any of:
  - the same alignment, timer-width, M_ov and !legal conditions as AdEL, applied to stores;
  - any store to a timer Count register (TIMER_BASE+16k+8);
  - sh/sb to the IG window.
- Non-memory instructions never raise 4/5.
- Interrupts:
  - hw_int passes through a 2-flop synchroniser to produce ip.
  - int_pend = |(ip & im) & ie & !exl.
- Request logic:
  - exc_req = int_pend | (M_code≠0 & !exl).
  - exc_is_int = int_pend (interrupt wins over a simultaneous M exception).
- EXL:
  - exl←1 on the edge after exc_req.
  - exl←0 on the edge with eret_M.
  - exc_req and eret_M in the same cycle: exl←1.
- While exl=1, codes still propagate, but exc_req stays 0. The offending instruction is dropped by the normal pipeline, not stalled here.
- Latency:
  - An interrupt edge reaches ip after 2 clocks.
  - exc_req follows combinationally in that same cycle when enabled.

Test Plan:
- Reset mid-run: hold faults, pulse reset low between edges → all outputs 0 immediately, exl=0.
- Oldest wins: F_code=4 with D_syscall=1, D_en=1; next cycle E_overflow=1 with E_ov_en=1 → E_code=4, then M_code=4, exc_req=1; following edge D/E/M codes=0, exl=1.
- Address map, one case per cycle:
  - lw M_addr=32'h2ffc → 0.
  - lw 32'h3000 → 4.
  - lh 32'h7f04 → 4.
  - sw 32'h7f08 → 5.
  - sw 32'h7f20 → 0.
  - sb 32'h7f20 → 5.
  - add with addr 32'h3000 → 0.
- Stall/bubble: D_syscall=1 with D_en=0 → E_reg unchanged; E_clr=1 and D_en=1 → E_code=0 next cycle.
- Interrupt: im=6'b000100, ie=1, hw_int[2] rises → exc_req=1 and exc_is_int=1 two edges later; with a concurrent M_code=5 → exc_is_int=1 still.
- EXL: with exl=1, M_code=12 → exc_req=0; eret_M pulse → exl=0 next edge; pending interrupt then fires.
